// File: rtl/store_merge_buffer.sv
// Store buffer: speculative FIFO of translated stores feeding a commit FIFO that drains to the D$,
// with optional same-word write merging on commit and a page-offset hazard check for the load unit.
module store_merge_buffer #(
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned PLEN         = 56,
   parameter int unsigned SPEC_DEPTH   = 4,
   parameter int unsigned COMMIT_DEPTH = 8,
   parameter bit          MERGE_EN     = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                push_valid_i,
   output logic                push_ready_o,
   input  logic [PLEN-1:0]     push_paddr_i,
   input  logic [DATA_W-1:0]   push_data_i,
   input  logic [DATA_W/8-1:0] push_be_i,
   input  logic                commit_i,
   output logic                commit_ready_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic [PLEN-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic [11:0]         page_offset_i,
   output logic                page_offset_matches_o,
   output logic                no_st_pending_o,
   output logic                empty_o
);
   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned OFF  = $clog2(BE_W);
   localparam int unsigned SP_W = $clog2(SPEC_DEPTH);
   localparam int unsigned CP_W = $clog2(COMMIT_DEPTH);
   localparam logic [SP_W:0] SPEC_FULL   = (SP_W+1)'(SPEC_DEPTH);
   localparam logic [CP_W:0] COMMIT_FULL = (CP_W+1)'(COMMIT_DEPTH);

   logic [PLEN-1:0]   spec_addr_q [SPEC_DEPTH];
   logic [PLEN-1:0]   spec_addr_d [SPEC_DEPTH];
   logic [DATA_W-1:0] spec_data_q [SPEC_DEPTH];
   logic [DATA_W-1:0] spec_data_d [SPEC_DEPTH];
   logic [BE_W-1:0]   spec_be_q   [SPEC_DEPTH];
   logic [BE_W-1:0]   spec_be_d   [SPEC_DEPTH];
   logic [SP_W-1:0]   spec_wptr_q, spec_wptr_d, spec_rptr_q, spec_rptr_d;
   logic [SP_W:0]     spec_cnt_q, spec_cnt_d;

   logic [PLEN-1:0]   cm_addr_q [COMMIT_DEPTH];
   logic [PLEN-1:0]   cm_addr_d [COMMIT_DEPTH];
   logic [DATA_W-1:0] cm_data_q [COMMIT_DEPTH];
   logic [DATA_W-1:0] cm_data_d [COMMIT_DEPTH];
   logic [BE_W-1:0]   cm_be_q   [COMMIT_DEPTH];
   logic [BE_W-1:0]   cm_be_d   [COMMIT_DEPTH];
   logic [CP_W-1:0]   cm_wptr_q, cm_wptr_d, cm_rptr_q, cm_rptr_d;
   logic [CP_W:0]     cm_cnt_q, cm_cnt_d;

   logic            push_fire, commit_fire, pop_fire, merge_hit, word_eq;
   logic [CP_W-1:0] youngest;
   logic [SP_W-1:0] spec_rel;
   logic [CP_W-1:0] cm_rel;

   assign push_ready_o    = spec_cnt_q != SPEC_FULL;
   assign mem_req_o       = cm_cnt_q != '0;
   assign no_st_pending_o = cm_cnt_q == '0;
   assign empty_o         = (spec_cnt_q == '0) && (cm_cnt_q == '0);
   assign mem_addr_o      = mem_req_o ? {cm_addr_q[cm_rptr_q][PLEN-1:OFF], {OFF{1'b0}}} : '0;
   assign mem_data_o      = mem_req_o ? cm_data_q[cm_rptr_q] : '0;
   assign mem_be_o        = mem_req_o ? cm_be_q[cm_rptr_q] : '0;

   always_comb begin
      spec_addr_d = spec_addr_q;
      spec_data_d = spec_data_q;
      spec_be_d   = spec_be_q;
      spec_wptr_d = spec_wptr_q;
      spec_rptr_d = spec_rptr_q;
      spec_cnt_d  = spec_cnt_q;
      cm_addr_d   = cm_addr_q;
      cm_data_d   = cm_data_q;
      cm_be_d     = cm_be_q;
      cm_wptr_d   = cm_wptr_q;
      cm_rptr_d   = cm_rptr_q;
      cm_cnt_d    = cm_cnt_q;

      youngest = cm_wptr_q - CP_W'(1);
      word_eq  = cm_addr_q[youngest][PLEN-1:OFF] == spec_addr_q[spec_rptr_q][PLEN-1:OFF];
      // A lone entry under request is never merged into, so request fields hold until grant.
      merge_hit = MERGE_EN && (cm_cnt_q != '0) && word_eq
                  && !((cm_cnt_q == (CP_W+1)'(1)) && mem_req_o);
      commit_ready_o = (spec_cnt_q != '0) && !flush_i && (merge_hit || (cm_cnt_q != COMMIT_FULL));
      push_fire   = push_valid_i && push_ready_o && !flush_i;
      commit_fire = commit_i && commit_ready_o;
      pop_fire    = mem_req_o && mem_gnt_i;

      if (flush_i) begin
         spec_cnt_d  = '0;
         spec_rptr_d = spec_wptr_q;
      end else begin
         if (push_fire) begin
            spec_addr_d[spec_wptr_q] = push_paddr_i;
            spec_data_d[spec_wptr_q] = push_data_i;
            spec_be_d[spec_wptr_q]   = push_be_i;
            spec_wptr_d              = spec_wptr_q + SP_W'(1);
         end
         if (commit_fire) spec_rptr_d = spec_rptr_q + SP_W'(1);
         spec_cnt_d = spec_cnt_q + (SP_W+1)'(push_fire) - (SP_W+1)'(commit_fire);
      end

      if (commit_fire) begin
         if (merge_hit) begin
            for (int b = 0; b < BE_W; b++) begin
               if (spec_be_q[spec_rptr_q][b])
                  cm_data_d[youngest][b*8 +: 8] = spec_data_q[spec_rptr_q][b*8 +: 8];
            end
            cm_be_d[youngest] = cm_be_q[youngest] | spec_be_q[spec_rptr_q];
         end else begin
            cm_addr_d[cm_wptr_q] = spec_addr_q[spec_rptr_q];
            cm_data_d[cm_wptr_q] = spec_data_q[spec_rptr_q];
            cm_be_d[cm_wptr_q]   = spec_be_q[spec_rptr_q];
            cm_wptr_d            = cm_wptr_q + CP_W'(1);
         end
      end
      if (pop_fire) cm_rptr_d = cm_rptr_q + CP_W'(1);
      cm_cnt_d = cm_cnt_q + (CP_W+1)'(commit_fire && !merge_hit) - (CP_W+1)'(pop_fire);
   end

   // Only live entries count; stale array contents outside the occupied window are ignored.
   always_comb begin
      page_offset_matches_o = push_valid_i && (push_paddr_i[11:OFF] == page_offset_i[11:OFF]);
      spec_rel = '0;
      cm_rel   = '0;
      for (int i = 0; i < SPEC_DEPTH; i++) begin
         spec_rel = SP_W'(i) - spec_rptr_q;
         if (({1'b0, spec_rel} < spec_cnt_q) && (spec_addr_q[i][11:OFF] == page_offset_i[11:OFF]))
            page_offset_matches_o = 1'b1;
      end
      for (int i = 0; i < COMMIT_DEPTH; i++) begin
         cm_rel = CP_W'(i) - cm_rptr_q;
         if (({1'b0, cm_rel} < cm_cnt_q) && (cm_addr_q[i][11:OFF] == page_offset_i[11:OFF]))
            page_offset_matches_o = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SPEC_DEPTH; i++) begin
            spec_addr_q[i] <= '0;
            spec_data_q[i] <= '0;
            spec_be_q[i]   <= '0;
         end
         for (int i = 0; i < COMMIT_DEPTH; i++) begin
            cm_addr_q[i] <= '0;
            cm_data_q[i] <= '0;
            cm_be_q[i]   <= '0;
         end
         spec_wptr_q <= '0;
         spec_rptr_q <= '0;
         spec_cnt_q  <= '0;
         cm_wptr_q   <= '0;
         cm_rptr_q   <= '0;
         cm_cnt_q    <= '0;
      end else begin
         spec_addr_q <= spec_addr_d;
         spec_data_q <= spec_data_d;
         spec_be_q   <= spec_be_d;
         spec_wptr_q <= spec_wptr_d;
         spec_rptr_q <= spec_rptr_d;
         spec_cnt_q  <= spec_cnt_d;
         cm_addr_q   <= cm_addr_d;
         cm_data_q   <= cm_data_d;
         cm_be_q     <= cm_be_d;
         cm_wptr_q   <= cm_wptr_d;
         cm_rptr_q   <= cm_rptr_d;
         cm_cnt_q    <= cm_cnt_d;
      end
   end
endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench for store_merge_buffer: a merging and a non-merging instance share one stimulus stream.
module tb_store_merge_buffer;
   logic        clk, rst_n, flush, push_valid, commit, gnt;
   logic [55:0] push_paddr;
   logic [63:0] push_data;
   logic [7:0]  push_be;
   logic [11:0] page_offset;

   logic        m_push_ready, m_commit_ready, m_req, m_match, m_no_st, m_empty;
   logic [55:0] m_addr;
   logic [63:0] m_data;
   logic [7:0]  m_be;
   logic        p_push_ready, p_commit_ready, p_req, p_match, p_no_st, p_empty;
   logic [55:0] p_addr;
   logic [63:0] p_data;
   logic [7:0]  p_be;

   int n_checks = 0;
   int n_errors = 0;

   store_merge_buffer #(.MERGE_EN(1'b1)) u_merge (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .push_valid_i(push_valid), .push_ready_o(m_push_ready), .push_paddr_i(push_paddr),
      .push_data_i(push_data), .push_be_i(push_be),
      .commit_i(commit), .commit_ready_o(m_commit_ready),
      .mem_req_o(m_req), .mem_gnt_i(gnt), .mem_addr_o(m_addr), .mem_data_o(m_data), .mem_be_o(m_be),
      .page_offset_i(page_offset), .page_offset_matches_o(m_match),
      .no_st_pending_o(m_no_st), .empty_o(m_empty)
   );

   store_merge_buffer #(.MERGE_EN(1'b0)) u_plain (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .push_valid_i(push_valid), .push_ready_o(p_push_ready), .push_paddr_i(push_paddr),
      .push_data_i(push_data), .push_be_i(push_be),
      .commit_i(commit), .commit_ready_o(p_commit_ready),
      .mem_req_o(p_req), .mem_gnt_i(gnt), .mem_addr_o(p_addr), .mem_data_o(p_data), .mem_be_o(p_be),
      .page_offset_i(page_offset), .page_offset_matches_o(p_match),
      .no_st_pending_o(p_no_st), .empty_o(p_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
      push_valid = 1'b1;
      push_paddr = a;
      push_data  = d;
      push_be    = be;
      tick();
      push_valid = 1'b0;
   endtask

   task automatic commit_n(input int n);
      commit = 1'b1;
      repeat (n) tick();
      commit = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; push_valid = 1'b0; commit = 1'b0; gnt = 1'b0;
      push_paddr = '0; push_data = '0; push_be = '0; page_offset = '0;

      // Reset values
      #3;
      chk("rst_push_ready", m_push_ready, 1);
      chk("rst_commit_ready", m_commit_ready, 0);
      chk("rst_mem_req", m_req, 0);
      chk("rst_match", m_match, 0);
      chk("rst_no_st", m_no_st, 1);
      chk("rst_empty", m_empty, 1);
      chk("rst_mem_addr", m_addr, 0);
      #9 rst_n = 1'b1;
      tick();

      // 1: single store end to end
      push(56'h1000, 64'h11, 8'h01);
      chk("t1_empty_after_push", m_empty, 0);
      chk("t1_no_st_after_push", m_no_st, 1);
      commit = 1'b1; #1;
      chk("t1_commit_ready", m_commit_ready, 1);
      tick(); commit = 1'b0;
      chk("t1_req", m_req, 1);
      chk("t1_addr", m_addr, 64'h1000);
      chk("t1_data", m_data, 64'h11);
      chk("t1_be", m_be, 8'h01);
      chk("t1_no_st", m_no_st, 0);
      gnt = 1'b1; tick(); gnt = 1'b0;
      chk("t1_req_done", m_req, 0);
      chk("t1_empty_done", m_empty, 1);

      // 2a: same word while the lone head is under request -> no merge
      push(56'h2000, 64'h0000_0000_AABB_CCDD, 8'h0F);
      push(56'h2004, 64'h1122_3344_0000_0000, 8'hF0);
      commit_n(2);
      chk("t2a_head_be", m_be, 8'h0F);
      chk("t2a_head_data", m_data, 64'h0000_0000_AABB_CCDD);
      gnt = 1'b1; tick();
      chk("t2a_second_addr", m_addr, 64'h2000);
      chk("t2a_second_be", m_be, 8'hF0);
      chk("t2a_second_data", m_data, 64'h1122_3344_0000_0000);
      tick(); gnt = 1'b0;
      chk("t2a_drained", m_req, 0);

      // 2b: youngest is not the requested head -> merge (MERGE_EN=1) vs two writes (MERGE_EN=0)
      push(56'h3000, 64'h55, 8'h01);
      push(56'h2000, 64'h0000_0000_AABB_CCDD, 8'h0F);
      push(56'h2004, 64'h1122_3344_0000_0000, 8'hF0);
      commit_n(3);
      chk("t2b_m_no_st", m_no_st, 0);
      gnt = 1'b1; #1;
      chk("t2b_m_head_addr", m_addr, 64'h3000);
      tick();
      chk("t2b_m_merged_addr", m_addr, 64'h2000);
      chk("t2b_m_merged_be", m_be, 8'hFF);
      chk("t2b_m_merged_data", m_data, 64'h1122_3344_AABB_CCDD);
      chk("t2b_p_first_be", p_be, 8'h0F);
      tick();
      chk("t2b_m_done", m_req, 0);
      chk("t2b_p_still_req", p_req, 1);
      chk("t2b_p_second_be", p_be, 8'hF0);
      chk("t2b_p_second_data", p_data, 64'h1122_3344_0000_0000);
      tick(); gnt = 1'b0;
      chk("t2b_p_done", p_req, 0);

      // 3: fill the speculative FIFO
      push(56'h4000, 64'h1, 8'hFF);
      push(56'h4008, 64'h2, 8'hFF);
      push(56'h4010, 64'h3, 8'hFF);
      chk("t3_ready_at_3", m_push_ready, 1);
      push(56'h4018, 64'h4, 8'hFF);
      chk("t3_full", m_push_ready, 0);
      commit_n(1);
      chk("t3_ready_after_commit", m_push_ready, 1);

      // 4: flush with a push and a commit in the same cycle
      flush = 1'b1; commit = 1'b1;
      push_valid = 1'b1; push_paddr = 56'h5000; push_data = 64'h9; push_be = 8'hFF;
      #1;
      chk("t4_commit_blocked_by_flush", m_commit_ready, 0);
      tick();
      flush = 1'b0; commit = 1'b0; push_valid = 1'b0;
      chk("t4_push_ready", m_push_ready, 1);
      chk("t4_no_st", m_no_st, 0);
      chk("t4_empty", m_empty, 0);
      commit = 1'b1; #1;
      chk("t4_spec_empty", m_commit_ready, 0);
      commit = 1'b0;
      gnt = 1'b1; #1;
      chk("t4_committed_addr", m_addr, 64'h4000);
      tick(); gnt = 1'b0;
      chk("t4_all_empty", m_empty, 1);

      // 5: page-offset hazard check
      push_valid = 1'b1; push_paddr = 56'h7008; push_data = 64'h7; push_be = 8'hFF;
      page_offset = 12'h008; #1;
      chk("t5_match_in_flight", m_match, 1);
      tick(); push_valid = 1'b0; #1;
      chk("t5_match_spec", m_match, 1);
      page_offset = 12'h010; #1;
      chk("t5_nomatch_010", m_match, 0);
      page_offset = 12'h00C; #1;
      chk("t5_match_same_word", m_match, 1);
      commit_n(1);
      page_offset = 12'h008; #1;
      chk("t5_match_commit", m_match, 1);
      gnt = 1'b1; tick(); gnt = 1'b0; #1;
      chk("t5_match_after_drain", m_match, 0);
      page_offset = '0;

      // 6: asynchronous reset while draining
      push(56'h8000, 64'hA, 8'hFF);
      push(56'h8040, 64'hB, 8'hFF);
      push(56'h8080, 64'hC, 8'hFF);
      commit_n(3);
      chk("t6_req_before_rst", m_req, 1);
      chk("t6_no_st_before_rst", m_no_st, 0);
      rst_n = 1'b0; #1;
      chk("t6_req_in_rst", m_req, 0);
      chk("t6_no_st_in_rst", m_no_st, 1);
      chk("t6_empty_in_rst", m_empty, 1);
      chk("t6_addr_in_rst", m_addr, 0);
      rst_n = 1'b1;
      tick();
      chk("t6_req_after_rst", m_req, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
